// File: rtl/calc_entry_ctrl_if.sv
// Operand/result handshake between the entry controller (master) and the
// two-operand calculator datapath (slave).
interface calc_entry_ctrl_if;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [1:0]  op;
  logic        calc_start;
  logic        calc_done;
  logic [15:0] res_bcd;
  logic        res_neg;

  modport master (
    output opa, opb, op, calc_start,
    input  calc_done, res_bcd, res_neg
  );

  modport slave (
    input  opa, opb, op, calc_start,
    output calc_done, res_bcd, res_neg
  );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Key-entry sequencer: builds two BCD operands and an operator from keyboard
// presses, launches the calculator, and formats the 4-digit display per state.
module calc_entry_ctrl #(
  parameter int CALC_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [8:0]              last_change,
  input  logic [511:0]            key_down,
  calc_entry_ctrl_if.master       calc,
  output logic [3:0]              disp3,
  output logic [3:0]              disp2,
  output logic [3:0]              disp1,
  output logic [3:0]              disp0,
  output logic                    err
);

  localparam int TW = $clog2(CALC_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CALC_TIMEOUT - 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_e;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_OP, K_ENTER, K_ESC, K_BS} key_kind_e;
  typedef struct packed {
    key_kind_e  kind;
    logic [3:0] val;
  } key_t;

  function automatic key_t decode(input logic [8:0] code);
    key_t k;
    k = '{kind: K_NONE, val: 4'd0};
    case (code)
      9'h045, 9'h070: k = '{kind: K_DIGIT, val: 4'd0};
      9'h016, 9'h069: k = '{kind: K_DIGIT, val: 4'd1};
      9'h01E, 9'h072: k = '{kind: K_DIGIT, val: 4'd2};
      9'h026, 9'h07A: k = '{kind: K_DIGIT, val: 4'd3};
      9'h025, 9'h06B: k = '{kind: K_DIGIT, val: 4'd4};
      9'h02E, 9'h073: k = '{kind: K_DIGIT, val: 4'd5};
      9'h036, 9'h074: k = '{kind: K_DIGIT, val: 4'd6};
      9'h03D, 9'h06C: k = '{kind: K_DIGIT, val: 4'd7};
      9'h03E, 9'h075: k = '{kind: K_DIGIT, val: 4'd8};
      9'h046, 9'h07D: k = '{kind: K_DIGIT, val: 4'd9};
      9'h079:         k = '{kind: K_OP,    val: 4'd0};
      9'h07B:         k = '{kind: K_OP,    val: 4'd1};
      9'h07C:         k = '{kind: K_OP,    val: 4'd2};
      9'h05A, 9'h15A: k = '{kind: K_ENTER, val: 4'd0};
      9'h076:         k = '{kind: K_ESC,   val: 4'd0};
      9'h066:         k = '{kind: K_BS,    val: 4'd0};
      default:        k = '{kind: K_NONE,  val: 4'd0};
    endcase
    return k;
  endfunction

  // Right-justified operand; an empty operand still shows a single 0.
  function automatic logic [15:0] fmt_operand(input logic [7:0] v, input logic [1:0] cnt);
    logic [15:0] f;
    case (cnt)
      2'd0:    f = 16'hFFF0;
      2'd1:    f = {12'hFFF, v[3:0]};
      default: f = {8'hFF, v};
    endcase
    return f;
  endfunction

  // Leading zeros blanked; minus sits left of the top digit, or overwrites disp3.
  function automatic logic [15:0] fmt_result(input logic [15:0] r, input logic neg);
    logic [15:0] f;
    int          msd;
    f   = 16'hFFFF;
    msd = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i*4 +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (i <= msd) f[i*4 +: 4] = r[i*4 +: 4];
    end
    if (neg) begin
      if (msd < 3) f[(msd+1)*4 +: 4] = 4'hA;
      else         f[15:12]          = 4'hA;
    end
    return f;
  endfunction

  state_e         state_q, state_d;
  logic [7:0]     opa_q, opa_d, opb_q, opb_d;
  logic [1:0]     op_q, op_d;
  logic [1:0]     cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [15:0]    res_q, res_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           start_q, start_d;
  logic [15:0]    disp_q, disp_d;

  key_t key;
  logic key_ev;

  assign key    = decode(last_change);
  assign key_ev = key_valid && key_down[last_change];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTER_A;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
      start_q <= 1'b0;
      disp_q  <= 16'hFFF0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      timer_q <= timer_d;
      start_q <= start_d;
      disp_q  <= disp_d;
    end
  end

  // NOTE: every variable gets a hold default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    res_d   = res_q;
    neg_d   = neg_q;
    err_d   = err_q;
    timer_d = timer_q;

    if (key_ev && key.kind == K_ESC) begin
      state_d = ENTER_A;
      opa_d   = '0;
      opb_d   = '0;
      op_d    = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ENTER_A: if (key_ev) begin
          case (key.kind)
            K_DIGIT: if (cnt_a_q < 2'd2) begin
              opa_d   = {opa_q[3:0], key.val};
              cnt_a_d = cnt_a_q + 2'd1;
            end
            K_BS: if (cnt_a_q != 2'd0) begin
              opa_d   = {4'h0, opa_q[7:4]};
              cnt_a_d = cnt_a_q - 2'd1;
            end
            K_OP: if (cnt_a_q != 2'd0) begin
              op_d    = key.val[1:0];
              opb_d   = '0;
              cnt_b_d = '0;
              state_d = ENTER_B;
            end
            default: ;
          endcase
        end
        ENTER_B: if (key_ev) begin
          case (key.kind)
            K_DIGIT: if (cnt_b_q < 2'd2) begin
              opb_d   = {opb_q[3:0], key.val};
              cnt_b_d = cnt_b_q + 2'd1;
            end
            K_BS: if (cnt_b_q != 2'd0) begin
              opb_d   = {4'h0, opb_q[7:4]};
              cnt_b_d = cnt_b_q - 2'd1;
            end else begin
              state_d = ENTER_A;
            end
            K_ENTER: if (cnt_b_q != 2'd0) begin
              timer_d = '0;
              state_d = CALC;
            end
            default: ;
          endcase
        end
        CALC: begin
          // A done seen alongside the start pulse belongs to an older request.
          if (calc.calc_done && !start_q) begin
            res_d   = calc.res_bcd;
            neg_d   = calc.res_neg;
            state_d = SHOW;
          end else if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            state_d = SHOW;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        SHOW: if (key_ev) begin
          case (key.kind)
            K_DIGIT: begin
              opa_d   = {4'h0, key.val};
              cnt_a_d = 2'd1;
              opb_d   = '0;
              cnt_b_d = '0;
              op_d    = '0;
              err_d   = 1'b0;
              state_d = ENTER_A;
            end
            K_OP: if (!neg_q && !err_q && res_q[15:8] == 8'h00) begin
              opa_d   = res_q[7:0];
              cnt_a_d = (res_q[7:4] != 4'h0) ? 2'd2 : 2'd1;
              op_d    = key.val[1:0];
              opb_d   = '0;
              cnt_b_d = '0;
              state_d = ENTER_B;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Outputs are precomputed from next-state values so they register in step.
  always_comb begin
    start_d = (state_d == CALC) && (state_q != CALC);
    disp_d  = disp_q;
    if (err_d) begin
      disp_d = 16'hEFFF;
    end else begin
      unique case (state_d)
        ENTER_A: disp_d = fmt_operand(opa_d, cnt_a_d);
        ENTER_B: disp_d = fmt_operand(opb_d, cnt_b_d);
        SHOW:    disp_d = fmt_result(res_d, neg_d);
        CALC:    disp_d = disp_q;
      endcase
    end
  end

  assign calc.opa        = opa_q;
  assign calc.opb        = opb_q;
  assign calc.op         = op_q;
  assign calc.calc_start = start_q;
  assign err             = err_q;
  assign {disp3, disp2, disp1, disp0} = disp_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: key sequences, calculator responses,
// timeout, esc and reset-in-flight, with hand-computed expectations.
module tb_calc_entry_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic [3:0]   disp3, disp2, disp1, disp0;
  logic         err;
  logic [15:0]  disp;

  int n_cmp   = 0;
  int n_bad   = 0;
  int n_start = 0;

  calc_entry_ctrl_if calc();

  calc_entry_ctrl #(.CALC_TIMEOUT(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .calc        (calc),
    .disp3       (disp3),
    .disp2       (disp2),
    .disp1       (disp1),
    .disp0       (disp0),
    .err         (err)
  );

  always #5 clk = ~clk;

  assign disp = {disp3, disp2, disp1, disp0};

  always @(posedge clk) if (calc.calc_start === 1'b1) n_start++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic press(input logic [8:0] code);
    @(negedge clk);
    last_change    = code;
    key_down[code] = 1'b1;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid      = 1'b0;
    key_down[code] = 1'b0;
  endtask

  task automatic release_key(input logic [8:0] code);
    @(negedge clk);
    last_change    = code;
    key_down[code] = 1'b0;
    key_valid      = 1'b1;
    @(negedge clk);
    key_valid      = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic done_pulse(input logic [15:0] res, input logic neg);
    calc.res_bcd   = res;
    calc.res_neg   = neg;
    calc.calc_done = 1'b1;
    @(negedge clk);
    calc.calc_done = 1'b0;
  endtask

  initial begin
    key_valid      = 1'b0;
    last_change    = '0;
    key_down       = '0;
    calc.calc_done = 1'b0;
    calc.res_bcd   = '0;
    calc.res_neg   = 1'b0;
    cycles(3);

    check("rst_opa",   calc.opa, 8'h00);
    check("rst_opb",   calc.opb, 8'h00);
    check("rst_op",    calc.op, 2'd0);
    check("rst_start", calc.calc_start, 1'b0);
    check("rst_err",   err, 1'b0);
    check("rst_disp",  disp, 16'hFFF0);
    rst = 1'b1;
    cycles(1);

    // 12 + 3 = 15
    press(9'h016); check("a1_opa", calc.opa, 8'h01); check("a1_disp", disp, 16'hFFF1);
    press(9'h01E); check("a12_opa", calc.opa, 8'h12); check("a12_disp", disp, 16'hFF12);
    press(9'h079); check("add_op", calc.op, 2'd0); check("b_empty_disp", disp, 16'hFFF0);
    press(9'h026); check("b3_opb", calc.opb, 8'h03); check("b3_disp", disp, 16'hFFF3);
    press(9'h05A);
    check("go1_start", calc.calc_start, 1'b1);
    check("go1_opa", calc.opa, 8'h12);
    check("go1_opb", calc.opb, 8'h03);
    cycles(1); check("go1_start_low", calc.calc_start, 1'b0);
    cycles(3);
    done_pulse(16'h0015, 1'b0);
    check("res15_disp", disp, 16'hFF15);
    check("res15_err", err, 1'b0);
    check("one_start", n_start, 1);

    // reuse result as A: 15 + 7 (keypad 7, extended enter), result -123
    press(9'h079); check("reuse_opa", calc.opa, 8'h15); check("reuse_disp", disp, 16'hFFF0);
    press(9'h06C); check("kp7_opb", calc.opb, 8'h07);
    press(9'h15A);
    check("go2_start", calc.calc_start, 1'b1);
    check("go2_op", calc.op, 2'd0);
    cycles(2);
    done_pulse(16'h0123, 1'b1);
    check("neg123_disp", disp, 16'hA123);
    press(9'h07B);
    check("neg_op_ignored_disp", disp, 16'hA123);
    check("neg_op_ignored_op", calc.op, 2'd0);
    press(9'h076); check("esc_disp", disp, 16'hFFF0);

    // third digit ignored, backspace, release ignored, enter in A ignored
    press(9'h025); press(9'h02E); press(9'h036);
    check("a45_opa", calc.opa, 8'h45); check("a45_disp", disp, 16'hFF45);
    press(9'h066); check("bs_opa", calc.opa, 8'h04); check("bs_disp", disp, 16'hFFF4);
    release_key(9'h016); check("release_opa", calc.opa, 8'h04);
    press(9'h05A); check("enter_a_start", calc.calc_start, 1'b0); check("enter_a_disp", disp, 16'hFFF4);
    press(9'h076); check("esc2_opa", calc.opa, 8'h00); check("esc2_disp", disp, 16'hFFF0);

    // operator with empty A ignored; backspace on empty B returns to A
    press(9'h079); press(9'h03E); check("op_cnt0_opa", calc.opa, 8'h08);
    press(9'h079); check("b_disp", disp, 16'hFFF0);
    press(9'h066); check("bs_back_disp", disp, 16'hFFF8);
    press(9'h046); check("back_a89", calc.opa, 8'h89); check("back_disp", disp, 16'hFF89);
    press(9'h076);

    // 5 - 9 = -4
    press(9'h02E); press(9'h07B); press(9'h046); press(9'h05A);
    check("sub_op", calc.op, 2'd1);
    cycles(1);
    done_pulse(16'h0004, 1'b1);
    check("neg4_disp", disp, 16'hFFA4);
    press(9'h03D);
    check("show_digit_opa", calc.opa, 8'h07);
    check("show_digit_op", calc.op, 2'd0);
    check("show_digit_disp", disp, 16'hFFF7);
    press(9'h076);

    // 2 * 3 with no done: timeout after 1024 CALC cycles
    press(9'h01E); press(9'h07C); press(9'h026); press(9'h05A);
    check("mul_op", calc.op, 2'd2);
    check("go4_start", calc.calc_start, 1'b1);
    cycles(1023); check("pre_timeout_err", err, 1'b0);
    cycles(1);
    check("timeout_err", err, 1'b1);
    check("timeout_disp", disp, 16'hEFFF);
    press(9'h076);
    check("esc_err", err, 1'b0);
    check("esc_err_disp", disp, 16'hFFF0);
    check("four_starts", n_start, 4);

    // done in the same cycle as start is ignored
    press(9'h016); press(9'h079); press(9'h016); press(9'h05A);
    done_pulse(16'h0002, 1'b0);
    check("early_done_disp", disp, 16'hFFF1);
    check("early_done_start", calc.calc_start, 1'b0);
    done_pulse(16'h0002, 1'b0);
    check("res2_disp", disp, 16'hFFF2);

    // 4-digit negative: minus replaces disp3
    press(9'h076);
    press(9'h016); press(9'h079); press(9'h016); press(9'h05A);
    cycles(1);
    done_pulse(16'h1234, 1'b1);
    check("neg1234_disp", disp, 16'hA234);
    check("six_starts", n_start, 6);

    // reset mid-CALC, late done ignored
    press(9'h076);
    press(9'h016); press(9'h079); press(9'h01E); press(9'h05A);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check("midrst_opa", calc.opa, 8'h00);
    check("midrst_disp", disp, 16'hFFF0);
    rst = 1'b1;
    cycles(1);
    done_pulse(16'h0003, 1'b0);
    check("late_done_disp", disp, 16'hFFF0);
    check("late_done_err", err, 1'b0);
    cycles(2);
    check("late_done_start", calc.calc_start, 1'b0);
    check("seven_starts", n_start, 7);
    press(9'h025);
    check("after_rst_opa", calc.opa, 8'h04);
    check("after_rst_disp", disp, 16'hFFF4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
